// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and step-direction encodings for the Gray step decoder.
// Pure definitions: no latency, no flow control.
package gray_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Callers zero-extend narrower codes; zero upper bits leave the lower result unchanged.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b     = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_decoder_if.sv
// Gray decoder signal bundle: code/control from the producer, decoded state back to it.
// No latency of its own; the decoder never backpressures, results are plain level/pulse outputs.
interface gray_step_decoder_if #(
    parameter int GRAYWIDTH = 3,
    parameter int POSWIDTH  = 16
);
    logic [GRAYWIDTH-1:0] gray_in;
    logic                 enable;
    logic                 clear;
    logic [GRAYWIDTH-1:0] bin;
    logic [POSWIDTH-1:0]  position;
    logic                 step_valid;
    logic                 step_dir;
    logic                 error;

    modport master (
        output gray_in, enable, clear,
        input  bin, position, step_valid, step_dir, error
    );

    modport slave (
        input  gray_in, enable, clear,
        output bin, position, step_valid, step_dir, error
    );
endinterface

// File: rtl/gray_input_sync.sv
// Two-flop synchroniser plus debounce; strobes once per newly settled code (2+STABLE_CYCLES cycles).
// No backpressure: enable=0 freezes the debounce count and suppresses acceptance.
module gray_input_sync #(
    parameter int GRAYWIDTH     = 3,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [GRAYWIDTH-1:0] gray_in,
    input  logic                 enable,
    output logic [GRAYWIDTH-1:0] cand,
    output logic                 settled,
    output logic                 accept_strobe
);

    localparam int            CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [GRAYWIDTH-1:0] s1;
    logic [GRAYWIDTH-1:0] s2;
    logic [GRAYWIDTH-1:0] accepted;
    logic [CW-1:0]        cnt;

    assign settled       = enable && (cnt == LAST);
    assign accept_strobe = settled && (cand != accepted);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            cand     <= '0;
            cnt      <= '0;
            accepted <= '0;
        end else begin
            s1 <= gray_in;
            s2 <= s1;
            // A new candidate always restarts the count, even while disabled.
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (enable && (cnt < LAST)) begin
                cnt <= cnt + CW'(1);
            end
            if (accept_strobe) begin
                accepted <= cand;
            end
        end
    end

endmodule

// File: rtl/gray_step_decoder.sv
// Gray code consumer: sync/debounce, decode, classify +1/-1/illegal, track position and error.
// step_valid registers 3+STABLE_CYCLES cycles after an input change; never backpressures.
module gray_step_decoder
    import gray_pkg::*;
#(
    parameter int GRAYWIDTH     = 3,
    parameter int POSWIDTH      = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_step_decoder_if.slave bus
);

    logic [GRAYWIDTH-1:0] cand;
    logic                 settled;
    logic                 accept;
    logic                 primed;
    logic [GRAYWIDTH-1:0] new_bin;
    logic [GRAYWIDTH-1:0] delta;
    logic                 is_up;
    logic                 is_down;

    logic [GRAYWIDTH-1:0] bin_q;
    logic [POSWIDTH-1:0]  position_q;
    logic                 step_valid_q;
    logic                 step_dir_q;
    logic                 error_q;

    gray_input_sync #(
        .GRAYWIDTH     (GRAYWIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .gray_in       (bus.gray_in),
        .enable        (bus.enable),
        .cand          (cand),
        .settled       (settled),
        .accept_strobe (accept)
    );

    assign new_bin = GRAYWIDTH'(gray2bin(32'(cand)));
    assign delta   = new_bin - bin_q;
    assign is_up   = (delta == GRAYWIDTH'(1));
    assign is_down = (delta == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed       <= 1'b0;
            bin_q        <= '0;
            position_q   <= '0;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // A settled all-zero code matches the reset baseline, so it primes without accepting.
            primed       <= primed | settled;
            step_valid_q <= 1'b0;
            if (accept) begin
                bin_q <= new_bin;
                if (primed) begin
                    if (is_up || is_down) begin
                        step_valid_q <= 1'b1;
                        step_dir_q   <= is_up ? DIR_UP : DIR_DOWN;
                        position_q   <= is_up ? position_q + POSWIDTH'(1)
                                              : position_q - POSWIDTH'(1);
                    end else begin
                        error_q <= 1'b1;
                    end
                end
            end
            // Clear overrides any same-cycle position or error update, but not the step pulse.
            if (bus.clear) begin
                position_q <= '0;
                error_q    <= 1'b0;
            end
        end
    end

    assign bus.bin        = bin_q;
    assign bus.position   = position_q;
    assign bus.step_valid = step_valid_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Self-checking bench for gray_step_decoder: directed vector table, corner sequences, random vs model.
module tb_gray_step_decoder;

    localparam int GW = 3;
    localparam int PW = 16;
    localparam int SC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_step_decoder_if #(.GRAYWIDTH(GW), .POSWIDTH(PW)) bus ();

    gray_step_decoder #(
        .GRAYWIDTH     (GW),
        .POSWIDTH      (PW),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] g;
        int         hold;
        int         pulses;
        int         dir;
        int         bin;
        int         pos;
        int         err;
    } vec_t;

    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;
    logic last_dir = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and counting step pulses.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.step_valid) begin
                pulses++;
                last_dir = bus.step_dir;
            end
        end
    endtask

    task automatic hold(input logic [2:0] g, input int n);
        bus.gray_in = g;
        pulses      = 0;
        run(n);
    endtask

    // Drive a code and raise clear for exactly the cycle where it is accepted.
    task automatic step_with_clear(input logic [2:0] g);
        bus.gray_in = g;
        repeat (SC + 2) @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    function automatic logic [2:0] to_gray(input int b);
        return 3'(b ^ (b >> 1));
    endfunction

    int         lat;
    int         mb;
    logic [15:0] mpos;
    int         merr;
    int         mdir;
    int         nb;
    int         d;
    int         exp_p;
    int         gl;

    initial begin
        vecs[0] = '{3'b001, 10, 1, 1, 1, 1,     0};
        vecs[1] = '{3'b011, 10, 1, 1, 2, 2,     0};
        vecs[2] = '{3'b010, 10, 1, 1, 3, 3,     0};
        vecs[3] = '{3'b011, 10, 1, 0, 2, 2,     0};
        vecs[4] = '{3'b001, 10, 1, 0, 1, 1,     0};
        vecs[5] = '{3'b000, 10, 1, 0, 0, 0,     0};
        vecs[6] = '{3'b100, 10, 1, 0, 7, 65535, 0};
        vecs[7] = '{3'b000, 10, 1, 1, 0, 0,     0};
        vecs[8] = '{3'b011, 10, 0, 1, 2, 0,     1};
        vecs[9] = '{3'b010, 10, 1, 1, 3, 1,     1};

        bus.gray_in = 3'b000;
        bus.enable  = 1'b1;
        bus.clear   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset bin", 32'(bus.bin), 0);
        check("reset position", 32'(bus.position), 0);
        check("reset step_valid", 32'(bus.step_valid), 0);
        check("reset step_dir", 32'(bus.step_dir), 0);
        check("reset error", 32'(bus.error), 0);
        rst_n = 1'b1;
        run(10);

        for (int i = 0; i < 10; i++) begin
            hold(vecs[i].g, vecs[i].hold);
            check($sformatf("vec%0d pulses", i), 32'(pulses), vecs[i].pulses);
            check($sformatf("vec%0d dir", i), 32'(bus.step_dir), vecs[i].dir);
            check($sformatf("vec%0d bin", i), 32'(bus.bin), vecs[i].bin);
            check($sformatf("vec%0d position", i), 32'(bus.position), vecs[i].pos);
            check($sformatf("vec%0d error", i), 32'(bus.error), vecs[i].err);
        end

        // Latency: bin 3 -> 4, pulse expected on the 7th sampled cycle.
        bus.gray_in = 3'b110;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.step_valid && lat == 0) lat = k;
        end
        check("latency", 32'(lat), 7);
        check("latency position", 32'(bus.position), 2);

        // Glitch of two cycles must not be accepted.
        pulses      = 0;
        bus.gray_in = 3'b111;
        run(2);
        bus.gray_in = 3'b110;
        run(10);
        check("glitch pulses", 32'(pulses), 0);
        check("glitch bin", 32'(bus.bin), 4);

        bus.clear = 1'b1;
        run(1);
        bus.clear = 1'b0;
        check("clear position", 32'(bus.position), 0);
        check("clear error", 32'(bus.error), 0);
        hold(3'b111, 10);
        hold(3'b101, 10);
        hold(3'b100, 10);
        hold(3'b000, 10);
        hold(3'b001, 10);
        check("walk position", 32'(bus.position), 5);

        step_with_clear(3'b011);
        check("clear+step step_valid", 32'(bus.step_valid), 1);
        check("clear+step position", 32'(bus.position), 0);
        check("clear+step error", 32'(bus.error), 0);
        check("clear+step dir", 32'(bus.step_dir), 1);
        run(5);

        step_with_clear(3'b111);
        check("clear+jump step_valid", 32'(bus.step_valid), 0);
        check("clear+jump error", 32'(bus.error), 0);
        check("clear+jump bin", 32'(bus.bin), 5);
        run(5);
        check("clear+jump error later", 32'(bus.error), 0);

        // Two codes advance while disabled; re-enable sees a jump of 2.
        bus.enable  = 1'b0;
        pulses      = 0;
        bus.gray_in = 3'b101;
        run(10);
        bus.gray_in = 3'b100;
        run(10);
        check("disabled pulses", 32'(pulses), 0);
        check("disabled bin", 32'(bus.bin), 5);
        bus.enable = 1'b1;
        run(10);
        check("reenable error", 32'(bus.error), 1);
        check("reenable pulses", 32'(pulses), 0);
        check("reenable bin", 32'(bus.bin), 7);

        // Reset while a legal 7 -> 0 step is still debouncing.
        bus.gray_in = 3'b000;
        run(3);
        rst_n = 1'b0;
        #1;
        check("midreset bin", 32'(bus.bin), 0);
        check("midreset position", 32'(bus.position), 0);
        check("midreset error", 32'(bus.error), 0);
        check("midreset step_dir", 32'(bus.step_dir), 0);
        @(negedge clk);
        run(2);
        rst_n  = 1'b1;
        pulses = 0;
        run(10);
        check("post-reset pulses", 32'(pulses), 0);
        check("post-reset bin", 32'(bus.bin), 0);
        hold(3'b001, 10);
        check("post-reset step", 32'(pulses), 1);
        check("post-reset position", 32'(bus.position), 1);

        mb   = 1;
        mpos = 16'd1;
        merr = 0;
        mdir = 1;
        for (int it = 0; it < 40; it++) begin
            nb     = int'($urandom_range(0, 7));
            pulses = 0;
            if ($urandom_range(0, 3) == 0) begin
                gl          = int'($urandom_range(0, 7));
                bus.gray_in = to_gray(gl);
                run(int'($urandom_range(1, 3)));
            end
            bus.gray_in = to_gray(nb);
            run(int'($urandom_range(8, 14)));

            exp_p = 0;
            if (nb != mb) begin
                d = (nb - mb) & 7;
                if (d == 1) begin
                    mpos  = mpos + 16'd1;
                    mdir  = 1;
                    exp_p = 1;
                end else if (d == 7) begin
                    mpos  = mpos - 16'd1;
                    mdir  = 0;
                    exp_p = 1;
                end else begin
                    merr = 1;
                end
                mb = nb;
            end
            check($sformatf("rand%0d pulses", it), 32'(pulses), exp_p);
            check($sformatf("rand%0d bin", it), 32'(bus.bin), mb);
            check($sformatf("rand%0d position", it), 32'(bus.position), 32'(mpos));
            check($sformatf("rand%0d error", it), 32'(bus.error), merr);
            check($sformatf("rand%0d dir", it), 32'(bus.step_dir), mdir);

            if (it % 8 == 7) begin
                bus.clear = 1'b1;
                run(1);
                bus.clear = 1'b0;
                mpos = 16'd0;
                merr = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
